// File: rtl/cdc_pkg.sv
// Shared types for the toggle-based req/ack bus crossing (sender and receiver).
package cdc_pkg;

  typedef enum logic [1:0] {
    RESYNC   = 2'd0,
    IDLE     = 2'd1,
    WAIT_ACK = 2'd2
  } cdc_tx_state_t;

endpackage

// File: rtl/sync_ffs.sv
// Plain multi-flop synchronizer. Deliberately not reset so that no reset path
// reaches the metastability-capturing flops.
module sync_ffs #(
  parameter int width  = 1,
  parameter int stages = 2
) (
  input  logic             clk,
  input  logic [width-1:0] d_i,
  output logic [width-1:0] q_o
);

  logic [stages-1:0][width-1:0] chain_q;

  // Shift the asynchronous input through the flop chain, newest sample at index 0.
  always_ff @(posedge clk) begin
    chain_q <= {chain_q[stages-2:0], d_i};
  end

  assign q_o = chain_q[stages-1];

endmodule

// File: rtl/cdc_bus_sender.sv
// Source-domain end of a toggle req/ack multi-bit crossing. A word accepted on
// valid/ready is held on cdc_data while cdc_req toggles; the next word is only
// taken once the synchronized ack toggle level equals the request level again.
module cdc_bus_sender
  import cdc_pkg::*;
#(
  parameter int width   = 32,
  parameter int stages  = 2,
  parameter int timeout = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [width-1:0] cdc_data,
  output logic             cdc_req,
  input  logic             cdc_ack,
  output logic             busy,
  output logic             timeout_err
);

  cdc_tx_state_t    state_q, state_d;
  logic             req_q, req_d;
  logic [width-1:0] data_q, data_d;
  logic             err_q, err_d;
  logic             ack_s;
  logic             ack_match;
  logic             timer_expire;

  sync_ffs #(
    .width  (1),
    .stages (stages)
  ) u_ack_sync (
    .clk (clk),
    .d_i (cdc_ack),
    .q_o (ack_s)
  );

  // The destination has caught up when its ack level equals our req level.
  assign ack_match = (ack_s == req_q);

  // Next-state logic: resync after reset, accept in IDLE, wait for the ack toggle.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      RESYNC: begin
        if (ack_match) state_d = IDLE;
      end
      IDLE: begin
        if (valid_in) begin
          data_d  = data_in;
          req_d   = ~req_q;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_match) state_d = IDLE;
        else if (timer_expire) err_d = 1'b1;
      end
      default: state_d = RESYNC;
    endcase
  end

  // State, request toggle, held word and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESYNC;
      req_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  generate
    if (timeout > 0) begin : g_timer
      localparam int TW = $clog2(timeout + 1);
      localparam logic [TW-1:0] TMAX = TW'(timeout - 1);

      logic [TW-1:0] timer_q, timer_d;
      logic          expire;

      // Count WAIT_ACK cycles without a match; saturate at the limit and flag it.
      always_comb begin
        timer_d = timer_q;
        expire  = 1'b0;
        if (state_q == IDLE && valid_in) begin
          timer_d = '0;
        end else if (state_q == WAIT_ACK && !ack_match) begin
          if (timer_q == TMAX) expire  = 1'b1;
          else                 timer_d = timer_q + TW'(1);
        end
      end

      // Timer register.
      always_ff @(posedge clk) begin
        if (rst) timer_q <= '0;
        else     timer_q <= timer_d;
      end

      assign timer_expire = expire;
    end else begin : g_no_timer
      assign timer_expire = 1'b0;
    end
  endgenerate

  assign ready_out   = (state_q == IDLE);
  assign busy        = (state_q == WAIT_ACK);
  assign cdc_data    = data_q;
  assign cdc_req     = req_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_cdc_bus_sender.sv
// Randomized bench for cdc_bus_sender. The reference model works in absolute
// cycle numbers: from the accept edge and the chosen ack delay it computes the
// edge at which ready must return and whether the timeout must fire.
module tb_cdc_bus_sender;

  localparam int W     = 32;
  localparam int STG   = 2;
  localparam int TO    = 10;
  localparam int NEVER = 1 << 30;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic         ready_out;
  logic [W-1:0] cdc_data;
  logic         cdc_req;
  logic         cdc_ack;
  logic         busy;
  logic         timeout_err;

  always #5 clk = ~clk;

  cdc_bus_sender #(
    .width   (W),
    .stages  (STG),
    .timeout (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .cdc_data    (cdc_data),
    .cdc_req     (cdc_req),
    .cdc_ack     (cdc_ack),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Model state: cyc counts rising edges; t_rdy is the edge after which ready is high.
  int           cyc      = 0;
  int           t_rdy    = NEVER;
  int           t_acc    = 0;
  int           ack_due  = -1;
  logic         ack_due_val = 1'b0;
  bit           have_xfer = 1'b0;
  logic         exp_req  = 1'b0;
  logic [W-1:0] exp_data = '0;
  logic         exp_err  = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  // Advance one edge, update the model, then compare every output.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      exp_req   = 1'b0;
      exp_data  = '0;
      exp_err   = 1'b0;
      t_rdy     = NEVER;
      have_xfer = 1'b0;
      ack_due   = -1;
    end
    if (cyc == ack_due) cdc_ack = ack_due_val;
    if (have_xfer && cyc == t_acc + TO && t_rdy > cyc) exp_err = 1'b1;
    check("ready", W'(ready_out), W'(cyc >= t_rdy));
    check("busy", W'(busy), W'(have_xfer && cyc < t_rdy));
    check("req", W'(cdc_req), W'(exp_req));
    check("data", cdc_data, exp_data);
    check("terr", W'(timeout_err), W'(exp_err));
  endtask

  // Drive inputs for the next edge; d is the ack delay in cycles (<0: never).
  task automatic drive(input logic v, input logic [W-1:0] dat, input int d);
    valid_in = v;
    data_in  = dat;
    if (!rst && v && cyc >= t_rdy) begin
      t_acc     = cyc + 1;
      exp_req   = ~exp_req;
      exp_data  = dat;
      have_xfer = 1'b1;
      if (d < 0) begin
        t_rdy   = NEVER;
        ack_due = -1;
      end else begin
        t_rdy       = t_acc + d + 1 + STG;
        ack_due     = t_acc + d;
        ack_due_val = exp_req;
      end
      $display("xfer edge=%0d data=%h req=%0b ack_delay=%0d", t_acc, dat, exp_req, d);
    end
  endtask

  logic [W-1:0] words [3];
  int           idx;

  initial begin
    words[0] = 32'h1;
    words[1] = 32'h2;
    words[2] = 32'h3;

    // Reset with valid held high: nothing may be accepted.
    rst      = 1'b1;
    cdc_ack  = 1'b0;
    valid_in = 1'b1;
    data_in  = 32'hA5A5_A5A5;
    repeat (3) tick();
    rst   = 1'b0;
    t_rdy = cyc + 1;
    drive(1'b0, '0, 0);
    repeat (2) tick();

    // Single word, ack returned five cycles after the accept.
    drive(1'b1, 32'hDEAD_BEEF, 5);
    tick();
    drive(1'b0, $urandom, 0);
    repeat (10) tick();

    // Back-to-back words with instant loopback; data_in churns while waiting.
    idx = 0;
    for (int k = 0; k < 40 && idx < 3; k++) begin
      if (cyc >= t_rdy) begin
        drive(1'b1, words[idx], 0);
        idx++;
      end else begin
        drive(1'b1, $urandom, 0);
      end
      tick();
    end
    drive(1'b0, '0, 0);
    repeat (5) tick();

    // No ack: timeout fires and stays; a late ack still completes.
    drive(1'b1, 32'hC0FF_EE00, -1);
    tick();
    drive(1'b0, $urandom, 0);
    repeat (14) tick();
    cdc_ack = exp_req;
    t_rdy   = cyc + 1 + STG;
    repeat (6) tick();

    // Reset in the middle of WAIT_ACK with a stale ack level of 1.
    drive(1'b1, 32'h1234_5678, -1);
    tick();
    drive(1'b0, $urandom, 0);
    repeat (2) tick();
    rst     = 1'b1;
    cdc_ack = 1'b1;
    drive(1'b1, $urandom, 0);
    repeat (3) tick();
    rst = 1'b0;
    drive(1'b0, '0, 0);
    repeat (5) tick();
    cdc_ack = 1'b0;
    t_rdy   = cyc + 1 + STG;
    repeat (5) tick();

    // Random traffic with random ack delays, some long enough to time out.
    repeat (400) begin
      drive(1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 9)));
      tick();
    end
    drive(1'b0, '0, 0);
    repeat (15) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
